// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the sequential restoring divider.
//   state_t                 - FSM state encoding (IDLE, CALC, FIX, DONE)
//   DIVIDER_WIDTH_DEFAULT   - default operand/quotient/remainder width
//   DIVIDER_ITERS_DEFAULT   - iteration count at the default width
//   divider_iters()         - iteration count (2*WIDTH) for any width
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DIVIDER_WIDTH_DEFAULT = 16;
    localparam int DIVIDER_ITERS_DEFAULT = 2 * DIVIDER_WIDTH_DEFAULT;

    // One quotient bit is produced per dividend bit.
    function automatic int divider_iters(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/divider_if.sv
// divider_if: request/result bundle between a client and the divider.
//   master: drives inp_start, inp_dividend (2*WIDTH), inp_divisor (WIDTH);
//           receives out_quotient, out_remainder (WIDTH), out_busy, out_done,
//           out_div_by_zero, out_overflow.
//   slave : the divider side of the same signals.
interface divider_if
    import divider_pkg::*;
#(
    parameter int WIDTH = DIVIDER_WIDTH_DEFAULT
);
    logic                   inp_start;
    logic [2*WIDTH-1:0]     inp_dividend;
    logic [WIDTH-1:0]       inp_divisor;
    logic [WIDTH-1:0]       out_quotient;
    logic [WIDTH-1:0]       out_remainder;
    logic                   out_busy;
    logic                   out_done;
    logic                   out_div_by_zero;
    logic                   out_overflow;

    modport master (
        output inp_start, inp_dividend, inp_divisor,
        input  out_quotient, out_remainder, out_busy, out_done,
               out_div_by_zero, out_overflow
    );

    modport slave (
        input  inp_start, inp_dividend, inp_divisor,
        output out_quotient, out_remainder, out_busy, out_done,
               out_div_by_zero, out_overflow
    );
endinterface

// File: rtl/divider_sign_fix.sv
// divider_sign_fix: combinational conditional two's-complement negate.
//   value  (W) - input word
//   negate (1) - when high, result = -value; otherwise result = value
//   result (W) - output word
// Feeding the word's own sign bit as 'negate' yields its magnitude; the
// magnitude of the most negative value is returned as an unsigned W-bit word.
module divider_sign_fix #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);
    assign result = negate ? (~value + W'(1)) : value;
endmodule

// File: rtl/divider.sv
// divider: sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per cycle, one-cycle out_done pulse.
//   inp_clk   - rising-edge clock
//   inp_rst_n - asynchronous active-low reset
//   bus       - divider_if.slave: start/operands in; quotient, remainder,
//               busy, done, div-by-zero and overflow out
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
// (truncating quotient, remainder carries the dividend's sign); otherwise
// operands are unsigned.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIVIDER_WIDTH_DEFAULT
) (
    input logic      inp_clk,
    input logic      inp_rst_n,
    divider_if.slave bus
);
    localparam int ITERS = divider_iters(WIDTH);
    localparam int CNT_W = $clog2(ITERS);

    state_t               state;
    logic [2*WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]     dsr;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   quo;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic                 overflow;

    logic [2*WIDTH-1:0]   dvd_in;
    logic [WIDTH-1:0]     dsr_in;
    logic [2*WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 ovf;

    // Shifted partial remainder is WIDTH+1 bits wide; since rem < dsr the
    // restored result always fits back into WIDTH bits.
    logic [WIDTH:0]       trial;
    logic                 fits;
    logic [WIDTH-1:0]     rem_next;

    assign trial    = {rem, dvd[2*WIDTH-1]};
    assign fits     = (trial >= {1'b0, dsr});
    assign rem_next = fits ? WIDTH'(trial - {1'b0, dsr}) : trial[WIDTH-1:0];

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    divider_sign_fix #(.W(2*WIDTH)) u_abs_dividend (
        .value (bus.inp_dividend),
        .negate(bus.inp_dividend[2*WIDTH-1]),
        .result(dvd_in)
    );

    divider_sign_fix #(.W(WIDTH)) u_abs_divisor (
        .value (bus.inp_divisor),
        .negate(bus.inp_divisor[WIDTH-1]),
        .result(dsr_in)
    );

    divider_sign_fix #(.W(2*WIDTH)) u_fix_quotient (
        .value (quo),
        .negate(neg_q),
        .result(quo_fix)
    );

    divider_sign_fix #(.W(WIDTH)) u_fix_remainder (
        .value (rem),
        .negate(neg_r),
        .result(rem_fix)
    );

    // Representable iff the top WIDTH+1 bits are a pure sign extension.
    assign ovf = !((&quo_fix[2*WIDTH-1:WIDTH-1]) || !(|quo_fix[2*WIDTH-1:WIDTH-1]));
`else
    assign dvd_in  = bus.inp_dividend;
    assign dsr_in  = bus.inp_divisor;
    assign quo_fix = quo;
    assign rem_fix = rem;
    assign ovf     = |quo_fix[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state       <= ST_IDLE;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.inp_start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        dvd         <= dvd_in;
                        dsr         <= dsr_in;
                        rem         <= '0;
                        quo         <= '0;
                        cnt         <= CNT_W'(ITERS - 1);
`ifdef DIVIDER_SIGNED_EN
                        neg_q       <= bus.inp_dividend[2*WIDTH-1] ^ bus.inp_divisor[WIDTH-1];
                        neg_r       <= bus.inp_dividend[2*WIDTH-1];
`endif
                        if (bus.inp_divisor == '0) begin
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= bus.inp_dividend[WIDTH-1:0];
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem <= rem_next;
                    quo <= {quo[2*WIDTH-2:0], fits};
                    dvd <= {dvd[2*WIDTH-2:0], 1'b0};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient  <= quo_fix[WIDTH-1:0];
                    remainder <= rem_fix;
                    overflow  <= ovf;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_quotient    = quotient;
    assign bus.out_remainder   = remainder;
    assign bus.out_busy        = busy;
    assign bus.out_done        = done;
    assign bus.out_div_by_zero = div_by_zero;
    assign bus.out_overflow    = overflow;

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed, table-driven bench for the divider (WIDTH = 16).
// Honours DIVIDER_SIGNED_EN so the vector table matches the build.
module tb_divider;
    logic clk;
    logic rst_n;

    divider_if #(.WIDTH(16)) bus ();

    divider #(.WIDTH(16)) dut (
        .inp_clk  (clk),
        .inp_rst_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dividend;
        logic [15:0] divisor;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands with start for one cycle; returns just after the accepting edge.
    task automatic launch(input logic [31:0] dvd, input logic [15:0] dsr);
        @(negedge clk);
        bus.inp_dividend = dvd;
        bus.inp_divisor  = dsr;
        bus.inp_start    = 1'b1;
        @(posedge clk);
        #1;
        bus.inp_start = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        check({tag, "_quotient"}, {16'd0, bus.out_quotient}, {16'd0, v.q});
        check({tag, "_remainder"}, {16'd0, bus.out_remainder}, {16'd0, v.r});
        check({tag, "_div_by_zero"}, {31'd0, bus.out_div_by_zero}, {31'd0, v.dz});
        check({tag, "_overflow"}, {31'd0, bus.out_overflow}, {31'd0, v.ov});
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_busy_in_done"}, {31'd0, bus.out_busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, bus.out_done}, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_quotient"}, {16'd0, bus.out_quotient}, 32'd0);
        check({tag, "_remainder"}, {16'd0, bus.out_remainder}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.out_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.out_done}, 32'd0);
        check({tag, "_div_by_zero"}, {31'd0, bus.out_div_by_zero}, 32'd0);
        check({tag, "_overflow"}, {31'd0, bus.out_overflow}, 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        int   t;
        int   done_cnt;
        int   done_t0;
        int   done_t1;
        vec_t v;

        // dividend, divisor, quotient, remainder, dz, ov, latency
        vecs.push_back('{32'd21845,    16'd1,     16'd21845, 16'd0,     1'b0, 1'b0, 34});
        vecs.push_back('{32'd21845,    16'd2,     16'd10922, 16'd1,     1'b0, 1'b0, 34});
        vecs.push_back('{32'd21844,    16'd2,     16'd10922, 16'd0,     1'b0, 1'b0, 34});
        vecs.push_back('{32'd100,      16'd7,     16'd14,    16'd2,     1'b0, 1'b0, 34});
        vecs.push_back('{32'd1000000,  16'd999,   16'd1001,  16'd1,     1'b0, 1'b0, 34});
        vecs.push_back('{32'd12345678, 16'd4321,  16'd2857,  16'd581,   1'b0, 1'b0, 34});
        vecs.push_back('{32'h00001234, 16'd0,     16'hFFFF,  16'h1234,  1'b1, 1'b0, 1});
        vecs.push_back('{32'h00010000, 16'd1,     16'h0000,  16'd0,     1'b0, 1'b1, 34});
        vecs.push_back('{32'd50,       16'd5,     16'd10,    16'd0,     1'b0, 1'b0, 34});
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back('{32'hFFFFFFFB, 16'hFFFF,  16'd5,     16'd0,     1'b0, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFF9, 16'd2,     16'hFFFD,  16'hFFFF,  1'b0, 1'b0, 34});
        vecs.push_back('{32'd7,        16'hFFFE,  16'hFFFD,  16'd1,     1'b0, 1'b0, 34});
        vecs.push_back('{32'h00008000, 16'd1,     16'h8000,  16'd0,     1'b0, 1'b1, 34});
        vecs.push_back('{32'hFFFF8000, 16'd1,     16'h8000,  16'd0,     1'b0, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFFF, 16'hFFFF,  16'd1,     16'd0,     1'b0, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFFB, 16'd0,     16'hFFFF,  16'hFFFB,  1'b1, 1'b0, 1});
`else
        vecs.push_back('{32'hFFFFFFFF, 16'hFFFF,  16'h0001,  16'd0,     1'b0, 1'b1, 34});
        vecs.push_back('{32'h7FFFFFFF, 16'h8000,  16'hFFFF,  16'h7FFF,  1'b0, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFFB, 16'd0,     16'hFFFF,  16'hFFFB,  1'b1, 1'b0, 1});
`endif

        rst_n            = 1'b0;
        bus.inp_start    = 1'b0;
        bus.inp_dividend = '0;
        bus.inp_divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            launch(v.dividend, v.divisor);
            check($sformatf("vec%0d_busy_after_start", i), {31'd0, bus.out_busy}, 32'd1);
            if (v.dz == 1'b0) begin
                check($sformatf("vec%0d_flags_cleared", i),
                      {30'd0, bus.out_div_by_zero, bus.out_overflow}, 32'd0);
            end
            wait_done(lat);
            check_result($sformatf("vec%0d", i), v, lat);
        end

        // A start pulse in the middle of CALC must neither restart nor queue.
        v = '{32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 34};
        launch(v.dividend, v.divisor);
        lat = 0;
        while (bus.out_done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) begin
                bus.inp_start    = 1'b1;
                bus.inp_dividend = 32'd50;
                bus.inp_divisor  = 16'd5;
            end else begin
                bus.inp_start = 1'b0;
            end
        end
        bus.inp_start = 1'b0;
        check_result("midcalc_start", v, lat);
        repeat (40) @(posedge clk);
        #1;
        check("midcalc_not_queued_busy", {31'd0, bus.out_busy}, 32'd0);

        // Asynchronous reset during CALC clears everything and suppresses done.
        launch(32'd21845, 16'd1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        v = '{32'd21845, 16'd2, 16'd10922, 16'd1, 1'b0, 1'b0, 34};
        launch(v.dividend, v.divisor);
        wait_done(lat);
        check_result("after_reset", v, lat);

        // Start held high: second operation is taken in the IDLE cycle after DONE.
        @(negedge clk);
        bus.inp_dividend = 32'd100;
        bus.inp_divisor  = 16'd7;
        bus.inp_start    = 1'b1;
        @(posedge clk);
        #1;
        t        = 0;
        done_cnt = 0;
        done_t0  = -1;
        done_t1  = -1;
        while (done_cnt < 2 && t < 150) begin
            @(posedge clk);
            #1;
            t++;
            if (bus.out_done === 1'b1) begin
                if (done_cnt == 0) done_t0 = t;
                else               done_t1 = t;
                done_cnt++;
            end
        end
        bus.inp_start = 1'b0;
        check("held_start_first_done", done_t0, 34);
        check("held_start_second_done", done_t1, 69);
        check("held_start_quotient", {16'd0, bus.out_quotient}, 32'd14);
        check("held_start_remainder", {16'd0, bus.out_remainder}, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("held_start_idle_busy", {31'd0, bus.out_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
